// File: rtl/k_and_s_control_unit.sv
// K&S 16-bit CPU control unit: a Moore sequencer that steps the datapath
// through fetch, decode and execute, with a parameterised RAM read latency.

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

// state     | meaning
// ----------+---------------------------------------------------------
// S_FETCH   | addr_sel=0 for MEM_LATENCY cycles, ir_enable on last
// S_DECODE  | one idle cycle, latches decoded_instruction
// S_ALU     | ALU result written to register file (ADD/SUB/AND/OR/MOVE)
// S_LOAD_RD | addr_sel=1 for MEM_LATENCY cycles while RAM read settles
// S_LOAD_WR | RAM data written to register file
// S_STORE   | register data written to ram[mem_addr]
// S_BR      | PC update, branch taken if condition holds on live flags
// S_NOP     | PC update only
// S_HALT    | halt=1, left only through rst_n
module k_and_s_control_unit
  import k_and_s_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter bit OV_SIGNED   = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_ALU, S_LOAD_RD, S_LOAD_WR, S_STORE, S_BR, S_NOP, S_HALT
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(MEM_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [1:0]              r_lat;
  logic [1:0]              w_lat_next;
  decoded_instruction_type r_instr;
  logic [CNT_W-1:0]        r_count;
  logic                    w_retire;
  logic                    w_lat_last;
  logic                    w_ov;
  logic                    w_br_cond;

  assign w_lat_last  = (r_lat == LAT_LAST);
  assign w_ov        = OV_SIGNED ? signed_overflow : unsigned_overflow;
  assign instr_count = r_count;

  // State, latency counter, latched instruction and retired-instruction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_lat   <= 2'd0;
      r_instr <= I_NOP;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_lat   <= w_lat_next;
      if (r_state == S_DECODE) r_instr <= decoded_instruction;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  // Branch condition evaluated on the flags present during the branch cycle.
  always_comb begin
    w_br_cond = 1'b0;
    case (r_instr)
      I_BRANCH: w_br_cond = 1'b1;
      I_BZERO:  w_br_cond = zero_op;
      I_BNZERO: w_br_cond = !zero_op;
      I_BNEG:   w_br_cond = neg_op;
      I_BNNEG:  w_br_cond = !neg_op;
      I_BOV:    w_br_cond = w_ov;
      I_BNOV:   w_br_cond = !w_ov;
      default:  w_br_cond = 1'b0;
    endcase
  end

  // Next-state selection and Moore output decode; outputs held low in reset.
  always_comb begin
    w_state_next     = r_state;
    w_lat_next       = r_lat;
    w_retire         = 1'b0;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_lat_last) begin
          ir_enable    = 1'b1;
          w_lat_next   = 2'd0;
          w_state_next = S_DECODE;
        end else begin
          w_lat_next = r_lat + 2'd1;
        end
      end
      S_DECODE: begin
        case (decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE:         w_state_next = S_ALU;
          I_LOAD:                                    w_state_next = S_LOAD_RD;
          I_STORE:                                   w_state_next = S_STORE;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:                    w_state_next = S_BR;
          I_HALT:                                    w_state_next = S_HALT;
          default:                                   w_state_next = S_NOP;
        endcase
      end
      S_ALU: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        // MOVE passes a|a through and must not disturb the flags.
        flags_reg_enable = (r_instr != I_MOVE);
        case (r_instr)
          I_ADD:   operation = 2'b01;
          I_SUB:   operation = 2'b10;
          I_AND:   operation = 2'b11;
          default: operation = 2'b00;
        endcase
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_LOAD_RD: begin
        addr_sel = 1'b1;
        if (w_lat_last) begin
          w_lat_next   = 2'd0;
          w_state_next = S_LOAD_WR;
        end else begin
          w_lat_next = r_lat + 2'd1;
        end
      end
      S_LOAD_WR: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        w_retire         = 1'b1;
        w_state_next     = S_FETCH;
      end
      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        pc_enable        = 1'b1;
        w_retire         = 1'b1;
        w_state_next     = S_FETCH;
      end
      S_BR: begin
        pc_enable    = 1'b1;
        branch       = w_br_cond;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_NOP: begin
        pc_enable    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        w_lat_next   = 2'd0;
        w_state_next = S_FETCH;
      end
    endcase
    if (!rst_n) begin
      w_retire         = 1'b0;
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = 2'b00;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
    end
  end

endmodule

// File: tb/tb_k_and_s_control_unit.sv
// Scoreboard bench for the K&S control unit. Two instances: dut0 with
// MEM_LATENCY=1/OV_SIGNED=1 and dut1 with MEM_LATENCY=3/OV_SIGNED=0.
module tb_k_and_s_control_unit;
  import k_and_s_pkg::*;

  // Output word layout: {halt, branch, pc, ir, addr_sel, c_sel, op[1:0], wre, fre, rwe}
  localparam logic [10:0] W_IDLE  = 11'b0_0_0_0_0_0_00_0_0_0;
  localparam logic [10:0] W_IR    = 11'b0_0_0_1_0_0_00_0_0_0;
  localparam logic [10:0] W_ADD   = 11'b0_0_1_0_0_1_01_1_1_0;
  localparam logic [10:0] W_SUB   = 11'b0_0_1_0_0_1_10_1_1_0;
  localparam logic [10:0] W_AND   = 11'b0_0_1_0_0_1_11_1_1_0;
  localparam logic [10:0] W_OR    = 11'b0_0_1_0_0_1_00_1_1_0;
  localparam logic [10:0] W_MOVE  = 11'b0_0_1_0_0_1_00_1_0_0;
  localparam logic [10:0] W_LDRD  = 11'b0_0_0_0_1_0_00_0_0_0;
  localparam logic [10:0] W_LDWR  = 11'b0_0_1_0_1_0_00_1_0_0;
  localparam logic [10:0] W_STORE = 11'b0_0_1_0_1_0_00_0_0_1;
  localparam logic [10:0] W_BR_T  = 11'b0_1_1_0_0_0_00_0_0_0;
  localparam logic [10:0] W_BR_N  = 11'b0_0_1_0_0_0_00_0_0_0;
  localparam logic [10:0] W_NOP   = 11'b0_0_1_0_0_0_00_0_0_0;
  localparam logic [10:0] W_HALT  = 11'b1_0_0_0_0_0_00_0_0_0;

  typedef struct {
    string       tag;
    logic [10:0] exp;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_s  [2];
  decoded_instruction_type dec_s  [2];
  logic                    zf_s   [2];
  logic                    nf_s   [2];
  logic                    uo_s   [2];
  logic                    so_s   [2];
  logic [15:0]             exp_cnt[2];

  logic        br0, pc0, ir0, as0, cs0, wre0, fre0, rwe0, h0;
  logic [1:0]  op0;
  logic [15:0] ic0;
  logic        br1, pc1, ir1, as1, cs1, wre1, fre1, rwe1, h1;
  logic [1:0]  op1;
  logic [15:0] ic1;

  exp_t qa[$];
  exp_t qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  k_and_s_control_unit #(.MEM_LATENCY(1), .OV_SIGNED(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_s[0]), .decoded_instruction(dec_s[0]),
    .zero_op(zf_s[0]), .neg_op(nf_s[0]),
    .unsigned_overflow(uo_s[0]), .signed_overflow(so_s[0]),
    .branch(br0), .pc_enable(pc0), .ir_enable(ir0), .addr_sel(as0),
    .c_sel(cs0), .operation(op0), .write_reg_enable(wre0),
    .flags_reg_enable(fre0), .ram_write_enable(rwe0), .halt(h0),
    .instr_count(ic0)
  );

  k_and_s_control_unit #(.MEM_LATENCY(3), .OV_SIGNED(1'b0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_s[1]), .decoded_instruction(dec_s[1]),
    .zero_op(zf_s[1]), .neg_op(nf_s[1]),
    .unsigned_overflow(uo_s[1]), .signed_overflow(so_s[1]),
    .branch(br1), .pc_enable(pc1), .ir_enable(ir1), .addr_sel(as1),
    .c_sel(cs1), .operation(op1), .write_reg_enable(wre1),
    .flags_reg_enable(fre1), .ram_write_enable(rwe1), .halt(h1),
    .instr_count(ic1)
  );

  task automatic check(input int s, input exp_t e);
    logic [10:0] got;
    logic [15:0] gcnt;
    if (s == 0) begin
      got  = {h0, br0, pc0, ir0, as0, cs0, op0, wre0, fre0, rwe0};
      gcnt = ic0;
    end else begin
      got  = {h1, br1, pc1, ir1, as1, cs1, op1, wre1, fre1, rwe1};
      gcnt = ic1;
    end
    n_tests++;
    if (got !== e.exp || gcnt !== e.cnt) begin
      n_fail++;
      $display("FAIL %s dut%0d: got out=%b cnt=%0d, expected out=%b cnt=%0d",
               e.tag, s, got, gcnt, e.exp, e.cnt);
    end
  endtask

  // Monitor: compare each presented cycle against the scoreboard queues.
  always @(negedge clk) begin
    if (qa.size() > 0) check(0, qa.pop_front());
    if (qb.size() > 0) check(1, qb.pop_front());
  end

  task automatic push(input int s, input string tag, input logic [10:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    x.cnt = exp_cnt[s];
    if (s == 0) qa.push_back(x);
    else        qb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input int s, input decoded_instruction_type ins, input string tag);
    int ml;
    ml = (s == 0) ? 1 : 3;
    dec_s[s] = I_HALT;
    for (int i = 0; i < ml; i++) begin
      push(s, {tag, "_fetch"}, (i == ml - 1) ? W_IR : W_IDLE);
      step();
    end
    dec_s[s] = ins;
    push(s, {tag, "_decode"}, W_IDLE);
    step();
    // Anything presented outside DECODE must be ignored.
    dec_s[s] = (ins == I_HALT) ? I_NOP : I_HALT;
  endtask

  task automatic issue(input int s, input decoded_instruction_type ins,
                       input logic z, input logic n, input logic u, input logic sv,
                       input logic [10:0] ex, input string tag);
    int ml;
    ml = (s == 0) ? 1 : 3;
    zf_s[s] = z; nf_s[s] = n; uo_s[s] = u; so_s[s] = sv;
    fetch_decode(s, ins, tag);
    if (ins == I_LOAD) begin
      for (int i = 0; i < ml; i++) begin
        push(s, {tag, "_rd"}, W_LDRD);
        step();
      end
    end
    push(s, {tag, "_exec"}, ex);
    exp_cnt[s] = exp_cnt[s] + 16'd1;
    step();
  endtask

  task automatic reset_now(input int s, input int cycles);
    rst_s[s]   = 1'b0;
    exp_cnt[s] = 16'd0;
    for (int i = 0; i < cycles; i++) begin
      push(s, "reset", W_IDLE);
      step();
    end
    rst_s[s] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b0; dec_s[s] = I_NOP; exp_cnt[s] = 16'd0;
      zf_s[s] = 1'b0; nf_s[s] = 1'b0; uo_s[s] = 1'b0; so_s[s] = 1'b0;
    end
    step();

    // dut0: MEM_LATENCY=1, OV_SIGNED=1; dut1 held in reset meanwhile.
    reset_now(0, 2);
    for (int i = 0; i < 10; i++) issue(0, I_NOP, 0, 0, 0, 0, W_NOP, "nop");
    issue(0, I_ADD,  0, 0, 0, 0, W_ADD,  "add");
    issue(0, I_SUB,  0, 0, 0, 0, W_SUB,  "sub");
    issue(0, I_MOVE, 0, 0, 0, 0, W_MOVE, "move");
    issue(0, I_AND,  0, 0, 0, 0, W_AND,  "and");
    issue(0, I_OR,   0, 0, 0, 0, W_OR,   "or");
    issue(0, I_BZERO,  1, 0, 0, 0, W_BR_T, "bzero_t");
    issue(0, I_BZERO,  0, 0, 0, 0, W_BR_N, "bzero_n");
    issue(0, I_BNZERO, 0, 0, 0, 0, W_BR_T, "bnzero_t");
    issue(0, I_BNEG,   0, 1, 0, 0, W_BR_T, "bneg_t");
    issue(0, I_BNNEG,  0, 1, 0, 0, W_BR_N, "bnneg_n");
    issue(0, I_BOV,    0, 0, 0, 1, W_BR_T, "bov_sgn_t");
    issue(0, I_BNOV,   0, 0, 0, 1, W_BR_N, "bnov_sgn_n");
    issue(0, I_BRANCH, 0, 0, 0, 0, W_BR_T, "branch");
    issue(0, I_STORE,  0, 0, 0, 0, W_STORE, "store");
    issue(0, I_LOAD,   0, 0, 0, 0, W_LDWR,  "load1");
    fetch_decode(0, I_HALT, "halt");
    for (int i = 0; i < 50; i++) begin
      push(0, "halt_hold", W_HALT);
      step();
    end
    reset_now(0, 2);
    issue(0, I_NOP, 0, 0, 0, 0, W_NOP, "post_halt_nop");
    push(0, "post_halt_fetch", W_IR);
    step();
    rst_s[0] = 1'b0;

    // dut1: MEM_LATENCY=3, OV_SIGNED=0.
    reset_now(1, 2);
    issue(1, I_LOAD, 0, 0, 0, 0, W_LDWR, "load3");
    issue(1, I_BOV,  0, 0, 0, 1, W_BR_N, "bov_uns_n");
    issue(1, I_BOV,  0, 0, 1, 0, W_BR_T, "bov_uns_t");
    issue(1, I_ADD,  0, 0, 0, 0, W_ADD,  "add3");
    fetch_decode(1, I_LOAD, "load_abort");
    push(1, "load_abort_rd", W_LDRD);
    step();
    reset_now(1, 2);
    issue(1, I_NOP, 0, 0, 0, 0, W_NOP, "post_abort_nop");

    step();
    step();
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/k_and_s_control_unit.md
Name: k_and_s_control_unit

Overview:
- Moore FSM that sequences the K&S 16-bit datapath through fetch, decode and execute.
- Drives every datapath strobe, the RAM write enable and a halt indication.
- Consumes the decoded instruction (k_and_s_pkg decoded_instruction_type) and the registered flags from the datapath.
- Sits beside the data path inside the CPU top level; RAM read latency is parameterised.

Parameters:
- MEM_LATENCY, 1, RAM read latency in cycles (1..4): cycles addr must be held before data_in is valid.
- OV_SIGNED, 1, 1: I_BOV/I_BNOV test signed_overflow; 0: test unsigned_overflow.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- decoded_instruction  in  decoded_instruction_type  current instruction class from datapath decoder
- zero_op / neg_op / unsigned_overflow / signed_overflow  in  1 each  registered ALU flags
- branch  out  1  PC loads mem_addr instead of PC+1
- pc_enable  out  1  PC update strobe
- ir_enable  out  1  instruction register load strobe
- addr_sel  out  1  0: ram_addr=PC, 1: ram_addr=mem_addr
- c_sel  out  1  0: register write data from RAM, 1: from ALU
- operation  out  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
- write_reg_enable  out  1  register file write strobe
- flags_reg_enable  out  1  flag register load strobe
- ram_write_enable  out  1  RAM write strobe (data_out -> ram[mem_addr])
- halt  out  1  CPU stopped
- instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, rst_n=0):
  - State enters FETCH; latency counter and instr_count clear to 0.
  - All outputs are 0, forced low combinationally while rst_n=0.
  - Asserting reset in any state, including HALT or mid-LOAD, aborts the instruction with no strobes afterwards.
- Outputs: decoded from state and latency counter only. Any strobe not listed for a state is 0; operation defaults to 00.
- FETCH:
  - Drives addr_sel=0 for MEM_LATENCY cycles.
  - Last cycle asserts ir_enable=1 -> DECODE.
- DECODE:
  - One cycle, no strobes.
  - Next state chosen by decoded_instruction: ALU, LOAD_RD, STORE, BR, NOP_S or HALT.
- ALU (I_ADD/I_SUB/I_AND/I_OR), 1 cycle:
  - c_sel=1, write_reg_enable=1, flags_reg_enable=1, pc_enable=1, branch=0.
  - operation = 01/10/11/00 respectively.
- ALU for I_MOVE: same as ALU but operation=00 (a|a) and flags_reg_enable=0.
- LOAD_RD: addr_sel=1 for MEM_LATENCY cycles -> LOAD_WR.
- LOAD_WR, 1 cycle: addr_sel=1, c_sel=0, write_reg_enable=1, pc_enable=1.
- STORE, 1 cycle: addr_sel=1, ram_write_enable=1, pc_enable=1.
- BR, 1 cycle: pc_enable=1; branch=1 iff the condition holds on the flags sampled in this cycle:
  - I_BRANCH: always
  - I_BZERO: zero_op; I_BNZERO: !zero_op
  - I_BNEG: neg_op; I_BNNEG: !neg_op
  - I_BOV: ov; I_BNOV: !ov, where ov is selected by OV_SIGNED
- NOP_S: pc_enable=1, 1 cycle.
- Every execute state's final cycle returns to FETCH and increments instr_count (mod 2^CNT_W).
- HALT:
  - halt=1, all strobes 0, instr_count frozen; only rst_n leaves HALT.
  - HALT is not counted as retired.
- Latency (cycles, FETCH through last execute cycle): ALU/MOVE/STORE/branch/NOP = MEM_LATENCY+2; LOAD = 2*MEM_LATENCY+2.
- Only one of write_reg_enable or ram_write_enable may be high in any cycle; ir_enable and pc_enable are never high together.
- Flags written in an ALU cycle are visible to any following branch, since at least FETCH and DECODE intervene.
- decoded_instruction is sampled only in DECODE; changes in other states are ignored.

Test Plan:
- Reset release, MEM_LATENCY=1, decoded=I_NOP continuously -> cycle 0: ir_enable=1, addr_sel=0; cycle 1: no strobes; cycle 2: pc_enable=1, branch=0; instr_count=1 after 3 cycles, 10 after 30.
- I_ADD then I_SUB -> EXEC cycles show operation=01 then 10, with c_sel=1, write_reg_enable=1, flags_reg_enable=1; I_MOVE -> operation=00, flags_reg_enable=0.
- MEM_LATENCY=3, I_LOAD -> addr_sel=0 for 3 cycles (ir_enable on 3rd), DECODE, addr_sel=1 for 3 cycles, then write_reg_enable=1 with c_sel=0; total 8 cycles.
- Conditional branches:
  - I_BZERO with zero_op=1 -> branch=1, pc_enable=1; with zero_op=0 -> branch=0.
  - I_BNEG with neg_op=1 -> branch=1.
  - I_BOV with signed_overflow=1, unsigned_overflow=0: OV_SIGNED=1 -> branch=1; OV_SIGNED=0 -> branch=0.
- I_STORE -> one cycle with addr_sel=1, ram_write_enable=1, write_reg_enable=0; I_HALT -> halt=1 held for 50 cycles, instr_count unchanged.
- Async reset mid-LOAD_RD and during HALT -> all outputs 0 immediately; after release, FETCH with instr_count=0 and halt=0.
